// File: rtl/id_operand_stage_if.sv
// Decode-operand stage bus: decoder inputs, producer forwarding taps, write-back port and ID/EX outputs.
interface id_operand_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned CNT_W  = 16
);
  // Decoder / control side
  logic              id_valid;
  logic [AW-1:0]     id_rs;
  logic [AW-1:0]     id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [AW-1:0]     id_dest;
  logic              id_wen;
  logic              id_is_load;
  logic [DATA_W-1:0] id_imm;
  logic              id_ready;

  // EXE producer
  logic              exe_valid;
  logic              exe_wen;
  logic              exe_is_load;
  logic [AW-1:0]     exe_dest;
  logic [DATA_W-1:0] exe_result;

  // MEM producer
  logic              mem_valid;
  logic              mem_wen;
  logic [AW-1:0]     mem_dest;
  logic [DATA_W-1:0] mem_result;

  // Write-back port
  logic              wb_wen;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] wb_data;

  // EXE-side control
  logic              ex_ready;
  logic              flush;

  // Forwarding observability and branch compare
  logic [1:0]        fwda;
  logic [1:0]        fwdb;
  logic              rs_eq_rt;

  // ID/EX register
  logic              ex_valid;
  logic [DATA_W-1:0] ex_da;
  logic [DATA_W-1:0] ex_db;
  logic [DATA_W-1:0] ex_imm;
  logic [AW-1:0]     ex_dest;
  logic              ex_wen;
  logic              ex_is_load;
  logic [CNT_W-1:0]  stall_cnt;

  // Stage side
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wen, id_is_load, id_imm,
    input  exe_valid, exe_wen, exe_is_load, exe_dest, exe_result,
    input  mem_valid, mem_wen, mem_dest, mem_result,
    input  wb_wen, wb_addr, wb_data,
    input  ex_ready, flush,
    output id_ready, fwda, fwdb, rs_eq_rt,
    output ex_valid, ex_da, ex_db, ex_imm, ex_dest, ex_wen, ex_is_load, stall_cnt
  );

  // Surrounding pipeline side
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dest, id_wen, id_is_load, id_imm,
    output exe_valid, exe_wen, exe_is_load, exe_dest, exe_result,
    output mem_valid, mem_wen, mem_dest, mem_result,
    output wb_wen, wb_addr, wb_data,
    output ex_ready, flush,
    input  id_ready, fwda, fwdb, rs_eq_rt,
    input  ex_valid, ex_da, ex_db, ex_imm, ex_dest, ex_wen, ex_is_load, stall_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-operand stage: register file, EXE/MEM/WB forwarding, load-use stall and ID/EX register.
module id_operand_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NREG    = 32,
  parameter bit          R0_ZERO = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk,
  input logic               reset,
  id_operand_stage_if.slave bus
);
  localparam int unsigned AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW:0] NREG_W = (AW + 1)'(NREG);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_EXE = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  logic [DATA_W-1:0] rf_q [NREG];

  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] ex_da_q, ex_da_d;
  logic [DATA_W-1:0] ex_db_q, ex_db_d;
  logic [DATA_W-1:0] ex_imm_q, ex_imm_d;
  logic [AW-1:0]     ex_dest_q, ex_dest_d;
  logic              ex_wen_q, ex_wen_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [AW-1:0]     src [2];
  logic              use_src [2];
  logic              exe_hit [2];
  logic [1:0]        sel [2];
  logic [DATA_W-1:0] opnd [2];
  logic              stall;
  logic              rf_we;

  // Register-file write; r0 stays zero when hardwired
  assign rf_we = bus.wb_wen && ({1'b0, bus.wb_addr} < NREG_W) &&
                 ((bus.wb_addr != '0) || !R0_ZERO);

  // Register file storage, cleared on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Operand resolution: EXE (non-load) > MEM > WB > regfile
  always_comb begin
    src[0]     = bus.id_rs;
    src[1]     = bus.id_rt;
    use_src[0] = bus.id_use_rs;
    use_src[1] = bus.id_use_rt;
    for (int k = 0; k < 2; k++) begin
      logic src_zero;
      logic mem_hit;
      logic wb_hit;
      logic [DATA_W-1:0] rf_val;
      src_zero   = R0_ZERO && (src[k] == '0);
      exe_hit[k] = use_src[k] && bus.exe_valid && bus.exe_wen &&
                   (bus.exe_dest == src[k]) && !src_zero;
      mem_hit    = use_src[k] && bus.mem_valid && bus.mem_wen &&
                   (bus.mem_dest == src[k]) && !src_zero;
      wb_hit     = use_src[k] && bus.wb_wen &&
                   (bus.wb_addr == src[k]) && !src_zero;
      rf_val     = '0;
      if (!src_zero && ({1'b0, src[k]} < NREG_W)) rf_val = rf_q[src[k]];
      sel[k]  = SEL_RF;
      opnd[k] = rf_val;
      if (exe_hit[k] && !bus.exe_is_load) begin
        sel[k]  = SEL_EXE;
        opnd[k] = bus.exe_result;
      end else if (mem_hit) begin
        sel[k]  = SEL_MEM;
        opnd[k] = bus.mem_result;
      end else if (wb_hit) begin
        sel[k]  = SEL_WB;
        opnd[k] = bus.wb_data;
      end
    end
  end

  // Load-use hazard against the EXE producer
  assign stall = bus.id_valid && bus.exe_valid && bus.exe_is_load && bus.exe_wen &&
                 (exe_hit[0] || exe_hit[1]);

  assign bus.id_ready = bus.ex_ready && !stall;
  assign bus.fwda     = sel[0];
  assign bus.fwdb     = sel[1];
  assign bus.rs_eq_rt = (opnd[0] == opnd[1]);

  // ID/EX next state: flush > backpressure hold > bubble > load
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_da_d      = ex_da_q;
    ex_db_d      = ex_db_q;
    ex_imm_d     = ex_imm_q;
    ex_dest_d    = ex_dest_q;
    ex_wen_d     = ex_wen_q;
    ex_is_load_d = ex_is_load_q;
    if (bus.flush) begin
      ex_valid_d = 1'b0;
    end else if (bus.ex_ready) begin
      if (stall || !bus.id_valid) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d   = 1'b1;
        ex_da_d      = opnd[0];
        ex_db_d      = opnd[1];
        ex_imm_d     = bus.id_imm;
        ex_dest_d    = bus.id_dest;
        ex_wen_d     = bus.id_wen;
        ex_is_load_d = bus.id_is_load;
      end
    end
  end

  // Saturating stall-cycle counter, unaffected by flush
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // ID/EX and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q   <= 1'b0;
      ex_da_q      <= '0;
      ex_db_q      <= '0;
      ex_imm_q     <= '0;
      ex_dest_q    <= '0;
      ex_wen_q     <= 1'b0;
      ex_is_load_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_da_q      <= ex_da_d;
      ex_db_q      <= ex_db_d;
      ex_imm_q     <= ex_imm_d;
      ex_dest_q    <= ex_dest_d;
      ex_wen_q     <= ex_wen_d;
      ex_is_load_q <= ex_is_load_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_da      = ex_da_q;
  assign bus.ex_db      = ex_db_q;
  assign bus.ex_imm     = ex_imm_q;
  assign bus.ex_dest    = ex_dest_q;
  assign bus.ex_wen     = ex_wen_q;
  assign bus.ex_is_load = ex_is_load_q;
  assign bus.stall_cnt  = stall_cnt_q;
endmodule
